// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Brief    : Shared types for the sequential ALU (opcodes, status, FSM state)
//  Revision : 1.0
// ============================================================================
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_SHL = 3'd4,
        OP_SHR = 3'd5,
        OP_MUL = 3'd6,
        OP_DIV = 3'd7
    } op_e;

    typedef struct packed {
        logic zero;
        logic negative;
        logic carry;
        logic overflow;
        logic div_by_zero;
    } status_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/seq_alu_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_alu_interface
//  Brief    : Request/response channels of the sequential ALU
//  Revision : 1.0
// ============================================================================
import alu_pkg::*;

interface seq_alu_interface #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    op_e              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    status_t          status;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, result_hi, status
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, result_hi, status
    );

    modport tb (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, result_hi, status
    );
endinterface
`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_muldiv_iter
//  Brief    : Iterative unsigned shift-add multiplier / restoring divider
//  Revision : 1.0
// ============================================================================
import alu_pkg::*;

module alu_muldiv_iter #(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             start_i,
    input  wire logic             is_div_i,
    input  wire logic [WIDTH-1:0] a_i,
    input  wire logic [WIDTH-1:0] b_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [WIDTH-1:0]      lo_o,
    output logic [WIDTH-1:0]      hi_o
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             is_div_q, is_div_d;
    logic [WIDTH-1:0] lo_q,     lo_d;
    logic [WIDTH-1:0] hi_q,     hi_d;
    logic [WIDTH-1:0] opb_q,    opb_d;

    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_shift;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_div_sub;

    // Partial remainder stays below the divisor, so the subtraction fits in WIDTH bits.
    always_comb begin
        w_mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        w_div_shift = {hi_q, lo_q[WIDTH-1]};
        w_div_ge    = (w_div_shift >= {1'b0, opb_q});
        w_div_sub   = w_div_shift[WIDTH-1:0] - opb_q;

        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        opb_d    = opb_q;

        if (start_i) begin
            cnt_d    = CNT_W'(WIDTH);
            is_div_d = is_div_i;
            lo_d     = a_i;
            hi_d     = '0;
            opb_d    = b_i;
        end else if (busy_o) begin
            cnt_d = cnt_q - 1'b1;
            if (is_div_q) begin
                hi_d = w_div_ge ? w_div_sub : w_div_shift[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], w_div_ge};
            end else begin
                hi_d = w_mul_sum[WIDTH:1];
                lo_d = {w_mul_sum[0], lo_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            lo_q     <= '0;
            hi_q     <= '0;
            opb_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            opb_q    <= opb_d;
        end
    end

    assign busy_o = (cnt_q != '0);
    assign done_o = (cnt_q == CNT_W'(1));
    assign lo_o   = lo_q;
    assign hi_o   = hi_q;

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module   : seq_alu
//  Brief    : Handshaked ALU; single-cycle simple ops, iterative MUL/DIV
//  Revision : 1.0
// ============================================================================
import alu_pkg::*;

module seq_alu #(
    parameter int WIDTH = 16
) (
    input wire logic        clk,
    input wire logic        rst,
    seq_alu_interface.slave bus
);
    localparam int SH_W = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] res_q,   res_d;
    logic [WIDTH-1:0] hi_q,    hi_d;
    logic             carry_q, carry_d;
    logic             ovf_q,   ovf_d;
    logic             dbz_q,   dbz_d;
    logic             iter_q,  iter_d;
    logic             mul_q,   mul_d;

    logic             w_accept, w_start, w_load, w_long_op;
    logic             w_it_busy, w_it_done;
    logic [WIDTH-1:0] w_it_lo, w_it_hi;
    logic [WIDTH:0]   w_sum, w_diff;
    logic [SH_W-1:0]  w_shamt;
    logic [WIDTH-1:0] w_s_res, w_s_hi, w_res_out, w_hi_out;
    logic             w_s_carry, w_s_ovf, w_s_dbz;

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .start_i  (w_start),
        .is_div_i (bus.op == OP_DIV),
        .a_i      (bus.a),
        .b_i      (bus.b),
        .busy_o   (w_it_busy),
        .done_o   (w_it_done),
        .lo_o     (w_it_lo),
        .hi_o     (w_it_hi)
    );

    assign bus.in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_long_op    = (bus.op == OP_MUL) || ((bus.op == OP_DIV) && (bus.b != '0));

    always_comb begin
        w_sum     = {1'b0, bus.a} + {1'b0, bus.b};
        w_diff    = {1'b0, bus.a} - {1'b0, bus.b};
        w_shamt   = bus.b[SH_W-1:0];
        w_s_res   = '0;
        w_s_hi    = '0;
        w_s_carry = 1'b0;
        w_s_ovf   = 1'b0;
        w_s_dbz   = 1'b0;
        case (bus.op)
            OP_ADD: begin
                w_s_res   = w_sum[WIDTH-1:0];
                w_s_carry = w_sum[WIDTH];
                w_s_ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                w_s_res   = w_diff[WIDTH-1:0];
                w_s_carry = w_diff[WIDTH];
                w_s_ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND: w_s_res = bus.a & bus.b;
            OP_OR:  w_s_res = bus.a | bus.b;
            OP_SHL: w_s_res = bus.a << w_shamt;
            OP_SHR: w_s_res = bus.a >> w_shamt;
            OP_DIV: begin
                w_s_res = '1;
                w_s_hi  = bus.a;
                w_s_dbz = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        w_start = 1'b0;
        w_load  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    state_d = w_long_op ? S_BUSY : S_DONE;
                    w_start = w_long_op;
                    w_load  = !w_long_op;
                end
            end
            S_BUSY: begin
                if (w_it_done) state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                    if (w_accept) begin
                        state_d = w_long_op ? S_BUSY : S_DONE;
                        w_start = w_long_op;
                        w_load  = !w_long_op;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        res_d   = res_q;
        hi_d    = hi_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;
        iter_d  = iter_q;
        mul_d   = mul_q;
        if (w_load) begin
            res_d   = w_s_res;
            hi_d    = w_s_hi;
            carry_d = w_s_carry;
            ovf_d   = w_s_ovf;
            dbz_d   = w_s_dbz;
            iter_d  = 1'b0;
        end else if (w_start) begin
            dbz_d  = 1'b0;
            iter_d = 1'b1;
            mul_d  = (bus.op == OP_MUL);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            res_q   <= '0;
            hi_q    <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
            iter_q  <= 1'b0;
            mul_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
            iter_q  <= iter_d;
            mul_q   <= mul_d;
        end
    end

    // Iterative results are read straight from the unit's registers; it holds once idle.
    assign w_res_out     = iter_q ? w_it_lo : res_q;
    assign w_hi_out      = iter_q ? w_it_hi : hi_q;
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = w_res_out;
    assign bus.result_hi = w_hi_out;

    // Flags read as zero whenever no result is being presented.
    assign bus.status.zero        = bus.out_valid && (w_res_out == '0);
    assign bus.status.negative    = bus.out_valid && w_res_out[WIDTH-1];
    assign bus.status.carry       = bus.out_valid && (iter_q ? (mul_q && (w_hi_out != '0)) : carry_q);
    assign bus.status.overflow    = bus.out_valid && !iter_q && ovf_q;
    assign bus.status.div_by_zero = bus.out_valid && dbz_q;

    logic w_unused;
    assign w_unused = w_it_busy;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_alu
//  Brief    : Directed self-checking bench for seq_alu at WIDTH=16
//  Revision : 1.0
// ============================================================================
import alu_pkg::*;

module tb_seq_alu;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    seq_alu_interface #(.WIDTH(16)) bus ();

    seq_alu #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input op_e op, input logic [15:0] a, input logic [15:0] b);
        int g;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        g = 0;
        while (!bus.in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("issue_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = 16'hDEAD;
        bus.b        = 16'hBEEF;
    endtask

    task automatic wait_out(input string tag, input int exp_lat);
        int lat;
        int rdy_seen;
        lat      = 0;
        rdy_seen = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!bus.out_valid && bus.in_ready) rdy_seen++;
        end while (!bus.out_valid && lat < 40);
        check({tag, "_lat"}, lat, exp_lat);
        if (exp_lat > 1) check({tag, "_busy_rdy"}, rdy_seen, 0);
    endtask

    task automatic pop();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int vcnt;
        n_tests       = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = OP_ADD;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_valid",  {31'd0, bus.out_valid}, 32'd0);
        check("rst_result", {16'd0, bus.result},    32'd0);
        check("rst_hi",     {16'd0, bus.result_hi}, 32'd0);
        check("rst_status", {27'd0, bus.status},    32'd0);
        rst = 1'b0;
        #1;
        check("rst_ready",  {31'd0, bus.in_ready},  32'd1);

        // ADD signed overflow
        issue(OP_ADD, 16'h7FFF, 16'h0001);
        wait_out("add", 1);
        check("add_res",    {16'd0, bus.result},    32'h8000);
        check("add_hi",     {16'd0, bus.result_hi}, 32'h0000);
        check("add_status", {27'd0, bus.status},    32'b01010);
        pop();
        check("add_popped", {31'd0, bus.out_valid}, 32'd0);

        // SUB borrow, then AND back-to-back
        issue(OP_SUB, 16'h0000, 16'h0001);
        wait_out("sub", 1);
        check("sub_res",    {16'd0, bus.result}, 32'hFFFF);
        check("sub_status", {27'd0, bus.status}, 32'b01100);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op        = OP_AND;
        bus.a         = 16'h00F0;
        bus.b         = 16'h0F00;
        #1;
        check("b2b_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("and_valid",  {31'd0, bus.out_valid}, 32'd1);
        check("and_res",    {16'd0, bus.result},    32'h0000);
        check("and_status", {27'd0, bus.status},    32'b10000);
        pop();

        // ADD carry-out wrapping to zero; SUB signed overflow
        issue(OP_ADD, 16'hFFFF, 16'h0001);
        wait_out("addc", 1);
        check("addc_status", {27'd0, bus.status}, 32'b10100);
        pop();
        issue(OP_SUB, 16'h8000, 16'h0001);
        wait_out("subv", 1);
        check("subv_res",    {16'd0, bus.result}, 32'h7FFF);
        check("subv_status", {27'd0, bus.status}, 32'b00010);
        pop();

        // SHR ignores upper bits of b
        issue(OP_SHR, 16'h8000, 16'h002F);
        wait_out("shr", 1);
        check("shr_res", {16'd0, bus.result}, 32'h0001);
        pop();

        // MUL
        issue(OP_MUL, 16'h1234, 16'h0100);
        wait_out("mul", 17);
        check("mul_res",    {16'd0, bus.result},    32'h3400);
        check("mul_hi",     {16'd0, bus.result_hi}, 32'h0012);
        check("mul_status", {27'd0, bus.status},    32'b00100);
        pop();

        issue(OP_MUL, 16'hFFFF, 16'hFFFF);
        wait_out("mulmax", 17);
        check("mulmax_res", {16'd0, bus.result},    32'h0001);
        check("mulmax_hi",  {16'd0, bus.result_hi}, 32'hFFFE);
        pop();

        // DIV
        issue(OP_DIV, 16'd100, 16'd7);
        wait_out("div", 17);
        check("div_res",    {16'd0, bus.result},    32'd14);
        check("div_hi",     {16'd0, bus.result_hi}, 32'd2);
        check("div_status", {27'd0, bus.status},    32'b00000);
        pop();

        issue(OP_DIV, 16'h1234, 16'h0000);
        wait_out("div0", 1);
        check("div0_res",    {16'd0, bus.result},    32'hFFFF);
        check("div0_hi",     {16'd0, bus.result_hi}, 32'h1234);
        check("div0_status", {27'd0, bus.status},    32'b01001);
        pop();

        // Backpressure with a pending request
        issue(OP_SHL, 16'h0001, 16'h0013);
        wait_out("shl", 1);
        bus.in_valid = 1'b1;
        bus.op       = OP_OR;
        bus.a        = 16'h00F0;
        bus.b        = 16'h0F00;
        for (int i = 0; i < 5; i++) begin
            check("bp_res",   {16'd0, bus.result},    32'h0008);
            check("bp_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp_ready", {31'd0, bus.in_ready},  32'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("or_res", {16'd0, bus.result}, 32'h0FF0);
        pop();

        // Reset in the middle of a MUL
        issue(OP_MUL, 16'h1234, 16'h0100);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mrst_valid",  {31'd0, bus.out_valid}, 32'd0);
        check("mrst_res",    {16'd0, bus.result},    32'd0);
        check("mrst_hi",     {16'd0, bus.result_hi}, 32'd0);
        check("mrst_status", {27'd0, bus.status},    32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mrst_ready", {31'd0, bus.in_ready}, 32'd1);
        issue(OP_ADD, 16'd2, 16'd3);
        wait_out("post", 1);
        check("post_res",    {16'd0, bus.result}, 32'd5);
        check("post_status", {27'd0, bus.status}, 32'b00000);
        pop();
        vcnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid) vcnt++;
        end
        check("mrst_discard", vcnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
`default_nettype wire
